// File: rtl/nbit_cpu.sv
// nbit_cpu: single-cycle accumulator CPU with RUN/HALT FSM.
// Optional B counter with LDB/DJNZ enabled by macro NBIT_CPU_DJNZ_EN.
`default_nettype none

module nbit_cpu #(
   parameter int WIDTH = 4,
   parameter int AW    = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             run,
   output logic [AW-1:0]    addr,
   input  logic [WIDTH+2:0] data,
   output logic [WIDTH-1:0] A,
   output logic             carry,
   output logic             halted
);

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_NOT  = 3'b001;
   localparam logic [2:0] OP_LDI  = 3'b010;
   localparam logic [2:0] OP_ADD  = 3'b011;
   localparam logic [2:0] OP_LDB  = 3'b100;
   localparam logic [2:0] OP_DJNZ = 3'b101;
   localparam logic [2:0] OP_JZ   = 3'b110;
   localparam logic [2:0] OP_HLT  = 3'b111;

   state_t           state_q, state_d;
   logic [AW-1:0]    ip_q, ip_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic             carry_q, carry_d;

   logic [2:0]       w_op;
   logic [WIDTH-1:0] w_imm;
   logic [AW-1:0]    w_ip_inc;
   logic [WIDTH:0]   w_sum;

   assign w_op     = data[WIDTH+2:WIDTH];
   assign w_imm    = data[WIDTH-1:0];
   assign w_ip_inc = ip_q + AW'(1);
   assign w_sum    = {1'b0, a_q} + {1'b0, w_imm};

`ifdef NBIT_CPU_DJNZ_EN
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] w_b_dec;

   assign w_b_dec = b_q - WIDTH'(1);
`endif

   always_comb begin
      state_d = state_q;
      ip_d    = ip_q;
      a_d     = a_q;
      carry_d = carry_q;
`ifdef NBIT_CPU_DJNZ_EN
      b_d     = b_q;
`endif
      if (state_q == S_RUN && run) begin
         ip_d = w_ip_inc;
         case (w_op)
            OP_NOP: ;
            OP_NOT: a_d = ~a_q;
            OP_LDI: begin
               a_d     = w_imm;
               carry_d = 1'b0;
            end
            OP_ADD: {carry_d, a_d} = w_sum;
`ifdef NBIT_CPU_DJNZ_EN
            OP_LDB: b_d = w_imm;
            OP_DJNZ: begin
               b_d = w_b_dec;
               if (w_b_dec != '0) ip_d = w_imm[AW-1:0];
            end
`endif
            OP_JZ: begin
               if (a_q == '0) ip_d = w_imm[AW-1:0];
            end
            OP_HLT: begin
               // Halting instruction leaves IP pointing at itself.
               state_d = S_HALT;
               ip_d    = ip_q;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_RUN;
         ip_q    <= '0;
         a_q     <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ip_q    <= ip_d;
         a_q     <= a_d;
         carry_q <= carry_d;
      end
   end

`ifdef NBIT_CPU_DJNZ_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) b_q <= '0;
      else        b_q <= b_d;
   end
`endif

   assign addr   = ip_q;
   assign A      = a_q;
   assign carry  = carry_q;
   assign halted = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_nbit_cpu.sv
// tb_nbit_cpu: directed and randomized checks of nbit_cpu against an
// instruction-level reference model (WIDTH=4, AW=4).
`default_nettype none

module tb_nbit_cpu;
   localparam int W   = 4;
   localparam int AWD = 4;
   localparam int M   = 1 << W;
   localparam int NL  = 1 << AWD;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             run   = 1'b0;
   logic [AWD-1:0]   addr;
   logic [W+2:0]     data;
   logic [W-1:0]     A;
   logic             carry;
   logic             halted;

   logic [W+2:0]     mem [NL];

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   // reference model state
   int m_ip, m_a, m_b, m_c, m_halt;

   assign data = mem[addr];

   nbit_cpu #(.WIDTH(W), .AW(AWD)) dut (
      .clock (clock),
      .reset (reset),
      .run   (run),
      .addr  (addr),
      .data  (data),
      .A     (A),
      .carry (carry),
      .halted(halted)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W+2:0] ins(input int op, input int imm);
      logic [W+2:0] r;
      r = {op[2:0], imm[W-1:0]};
      return r;
   endfunction

   task automatic model_rst();
      m_ip = 0; m_a = 0; m_b = 0; m_c = 0; m_halt = 0;
   endtask

   // Executes one instruction by the ISA rules, using plain integer arithmetic.
   task automatic model_step();
      int op, imm, nxt, s;
      if (m_halt != 0 || run !== 1'b1) return;
      op  = int'(mem[m_ip][W+2:W]);
      imm = int'(mem[m_ip][W-1:0]);
      nxt = (m_ip + 1) % NL;
      m_ip = nxt;
      case (op)
         1: m_a = (M - 1) - m_a;
         2: begin m_a = imm; m_c = 0; end
         3: begin s = m_a + imm; m_a = s % M; m_c = s / M; end
`ifdef NBIT_CPU_DJNZ_EN
         4: m_b = imm;
         5: begin
            m_b = (m_b + M - 1) % M;
            if (m_b != 0) m_ip = imm % NL;
         end
`endif
         6: if (m_a == 0) m_ip = imm % NL;
         7: begin m_halt = 1; m_ip = (nxt + NL - 1) % NL; end
         default: ;
      endcase
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         check("addr",   int'(addr),   m_ip);
         check("A",      int'(A),      m_a);
         check("carry",  int'(carry),  m_c);
         check("halted", int'(halted), m_halt);
      end
   end

   // One clock: model advances with the DUT edge, inputs change 2ns later.
   task automatic cycle();
      @(posedge clock);
      if (reset) model_step();
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_rst();
      #1;
      check("rst_addr",   int'(addr),   0);
      check("rst_A",      int'(A),      0);
      check("rst_carry",  int'(carry),  0);
      check("rst_halted", int'(halted), 0);
      #1;
      reset = 1'b1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < NL; i++) mem[i] = ins(0, 0);
   endtask

   task automatic wait_halt(input string nm, input int budget);
      int k;
      k = 0;
      while (halted !== 1'b1 && k < budget) begin
         cycle();
         k++;
      end
      if (halted !== 1'b1) check({nm, "_timeout"}, 0, 1);
   endtask

   initial begin
      clear_mem();
      model_rst();
      #1;
      check("por_addr", int'(addr), 0);
      check("por_A",    int'(A),    0);
      @(posedge clock);
      #2;
      reset  = 1'b1;
      chk_en = 1'b1;

      // LDI 5; NOT; HLT
      clear_mem();
      mem[0] = ins(2, 5); mem[1] = ins(1, 0); mem[2] = ins(7, 0);
      do_reset();
      run = 1'b1;
      cycle(); check("p1_ldi", int'(A), 5);
      cycle(); check("p1_not", int'(A), 10);
      cycle(); check("p1_halt", int'(halted), 1);
      for (int i = 0; i < 4; i++) begin
         mem[2] = 7'($urandom);
         run = 1'($urandom);
         cycle();
         check("p1_hold_addr", int'(addr), 2);
         check("p1_hold_halt", int'(halted), 1);
      end

      // LDI 9; ADD 8; ADD 1
      clear_mem();
      mem[0] = ins(2, 9); mem[1] = ins(3, 8); mem[2] = ins(3, 1); mem[3] = ins(7, 0);
      do_reset();
      run = 1'b1;
      cycle(); cycle();
      check("add_ovf_A", int'(A), 1);
      check("add_ovf_c", int'(carry), 1);
      cycle();
      check("add_A", int'(A), 2);
      check("add_c", int'(carry), 0);

      // NOP sweep across the whole address space
      clear_mem();
      do_reset();
      run = 1'b1;
      for (int i = 1; i <= NL; i++) begin
         cycle();
         check("nop_addr", int'(addr), i % NL);
         check("nop_halt", int'(halted), 0);
      end

      // LDB 3; ADD 1; DJNZ 1; HLT
      clear_mem();
      mem[0] = ins(4, 3); mem[1] = ins(3, 1); mem[2] = ins(5, 1); mem[3] = ins(7, 0);
      do_reset();
      run = 1'b1;
      wait_halt("djnz", 20);
`ifdef NBIT_CPU_DJNZ_EN
      check("djnz_A", int'(A), 3);
`else
      check("djnz_A", int'(A), 1);
`endif
      check("djnz_addr", int'(addr), 3);

      // JZ taken / not taken
      clear_mem();
      mem[0] = ins(2, 0); mem[1] = ins(6, 7);
      do_reset();
      run = 1'b1;
      cycle(); cycle();
      check("jz_taken", int'(addr), 7);
      mem[0] = ins(2, 1);
      do_reset();
      cycle(); cycle();
      check("jz_fall", int'(addr), 2);

      // run low freezes state; reset between edges clears immediately
      clear_mem();
      mem[0] = ins(2, 5); mem[1] = ins(1, 0); mem[2] = ins(3, 3);
      do_reset();
      run = 1'b1;
      cycle();
      run = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("frz_A", int'(A), 5);
         check("frz_addr", int'(addr), 1);
      end
      run = 1'b1;
      cycle();
      check("resume_A", int'(A), 10);
      do_reset();

      // randomized programs, run toggling, occasional mid-program reset
      for (int seg = 0; seg < 40; seg++) begin
         for (int i = 0; i < NL; i++) begin
            mem[i] = 7'($urandom);
            if (mem[i][W+2:W] == 3'b111 && ($urandom % 3) != 0)
               mem[i][W+2:W] = 3'($urandom_range(0, 6));
         end
         do_reset();
         for (int c = 0; c < 40; c++) begin
            run = ($urandom % 4) != 0;
            if (($urandom % 6) == 0) mem[$urandom % NL] = 7'($urandom);
            if (($urandom % 25) == 0) do_reset();
            cycle();
         end
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
